// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Two-port request/acknowledge arbiter and access sequencer in front of a
// single-port synchronous RAM. Port 0 is instruction fetch and port 1 is
// data-tape access. One access is in flight at a time. Ties are broken
// round-robin. Each access walks IDLE -> ACCESS -> WAIT -> DONE. The requester
// sees a one-cycle Ack in DONE, three cycles after the grant edge.
//
// Ports:
//   Clk, Rst_n          clock (posedge) and synchronous active-low reset
//   Req0/Req1           level requests, held by the requester until its Ack
//   We0/We1             1 = write, 0 = read; sampled at grant
//   Addr0/Addr1         access address; sampled at grant
//   WData0/WData1       write data; sampled at grant
//   Ack0/Ack1           one-cycle completion pulse to the owning port
//   RData0/RData1       read result; held until the next read on that port
//   Busy                high whenever the sequencer is not idle
//   RamAddress, RamIn   address and write data to the RAM
//   RamOut              registered read data from the RAM
//   RamCS, RamWE_n      RAM chip select and active-low write enable
//
// Every output comes directly from a register.

module ram_arbiter #(
  parameter int AddressSize = 16,
  parameter int DataSize    = 10
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Req0,
  input  logic                   Req1,
  input  logic                   We0,
  input  logic                   We1,
  input  logic [AddressSize-1:0] Addr0,
  input  logic [AddressSize-1:0] Addr1,
  input  logic [DataSize-1:0]    WData0,
  input  logic [DataSize-1:0]    WData1,
  output logic                   Ack0,
  output logic                   Ack1,
  output logic [DataSize-1:0]    RData0,
  output logic [DataSize-1:0]    RData1,
  output logic                   Busy,
  output logic [AddressSize-1:0] RamAddress,
  output logic [DataSize-1:0]    RamIn,
  input  logic [DataSize-1:0]    RamOut,
  output logic                   RamCS,
  output logic                   RamWE_n
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic                   owner_reg, owner_next;
  logic                   last_reg, last_next;
  logic                   write_reg, write_next;
  logic [AddressSize-1:0] ram_address_reg, ram_address_next;
  logic [DataSize-1:0]    ram_in_reg, ram_in_next;
  logic                   ram_cs_reg, ram_cs_next;
  logic                   ram_we_n_reg, ram_we_n_next;
  logic                   busy_reg, busy_next;
  logic [1:0]             ack_reg, ack_next;

  // Per-port views of the request inputs so the grant logic can index by port.
  logic [1:0]             req_vec;
  logic [1:0]             we_vec;
  logic [AddressSize-1:0] addr_arr  [2];
  logic [DataSize-1:0]    wdata_arr [2];
  logic [DataSize-1:0]    rdata_reg [2];
  logic [1:0]             capture;

  assign req_vec      = {Req1, Req0};
  assign we_vec       = {We1, We0};
  assign addr_arr[0]  = Addr0;
  assign addr_arr[1]  = Addr1;
  assign wdata_arr[0] = WData0;
  assign wdata_arr[1] = WData1;

  // Grant selection: if both ports request, pick the one that did not win
  // last time. If only one requests, req_vec[1] names it directly.
  logic grant;
  always_comb begin
    grant = 1'b0;
    if (req_vec == 2'b11) begin
      grant = ~last_reg;
    end else begin
      grant = req_vec[1];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_next        = last_reg;
    write_next       = write_reg;
    ram_address_next = ram_address_reg;
    ram_in_next      = ram_in_reg;
    ram_cs_next      = 1'b0;
    ram_we_n_next    = 1'b1;
    ack_next         = 2'b00;

    case (state_reg)
      IDLE: begin
        if (req_vec != 2'b00) begin
          owner_next       = grant;
          last_next        = grant;
          write_next       = we_vec[grant];
          ram_address_next = addr_arr[grant];
          ram_in_next      = wdata_arr[grant];
          ram_cs_next      = 1'b1;
          // The write strobe is low only for the single ACCESS cycle.
          ram_we_n_next    = ~we_vec[grant];
          state_next       = ACCESS;
        end
      end
      ACCESS: begin
        // Keep the chip selected with the strobe high so the RAM drives
        // the word it registered at the end of ACCESS.
        ram_cs_next = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        ack_next   = owner_reg ? 2'b10 : 2'b01;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg       <= IDLE;
      owner_reg       <= 1'b0;
      last_reg        <= 1'b1;
      write_reg       <= 1'b0;
      ram_address_reg <= '0;
      ram_in_reg      <= '0;
      ram_cs_reg      <= 1'b0;
      ram_we_n_reg    <= 1'b1;
      busy_reg        <= 1'b0;
      ack_reg         <= 2'b00;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_reg        <= last_next;
      write_reg       <= write_next;
      ram_address_reg <= ram_address_next;
      ram_in_reg      <= ram_in_next;
      ram_cs_reg      <= ram_cs_next;
      ram_we_n_reg    <= ram_we_n_next;
      busy_reg        <= busy_next;
      ack_reg         <= ack_next;
    end
  end

  // Read-data holding registers, one per port. Each one loads only at the
  // edge that ends WAIT for a read it owns. It keeps its value otherwise.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
      assign capture[gi] = (state_reg == WAIT) && !write_reg &&
                           (owner_reg == 1'(gi));

      always_ff @(posedge Clk) begin
        if (!Rst_n) begin
          rdata_reg[gi] <= '0;
        end else if (capture[gi]) begin
          rdata_reg[gi] <= RamOut;
        end
      end
    end
  endgenerate

  assign Ack0       = ack_reg[0];
  assign Ack1       = ack_reg[1];
  assign RData0     = rdata_reg[0];
  assign RData1     = rdata_reg[1];
  assign Busy       = busy_reg;
  assign RamAddress = ram_address_reg;
  assign RamIn      = ram_in_reg;
  assign RamCS      = ram_cs_reg;
  assign RamWE_n    = ram_we_n_reg;

endmodule
